// File: rtl/online_div_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// online_div_pkg
// Shared definitions for the online divider scheduler:
//   - state_e   : scheduler FSM states
//   - SD_*      : radix-2 signed-digit encodings {plus,minus}
//   - cnt_width : width of the digit counters (holds 0..DIGITS+ONLINE_DELAY)
// -----------------------------------------------------------------------------
package online_div_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      FEED,
      PAD,
      DRAIN
   } state_e;

   localparam logic [1:0] SD_POS  = 2'b10;
   localparam logic [1:0] SD_NEG  = 2'b01;
   localparam logic [1:0] SD_ZERO = 2'b00;

   // Counters must be able to hold the terminal value DIGITS+ONLINE_DELAY.
   function automatic int cnt_width(input int digits, input int delay);
      return $clog2(digits + delay + 1);
   endfunction

endpackage

// File: rtl/online_div_scheduler_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick: scans req_i starting at index ptr_i,
// wrapping around, and returns the first set bit.
// Ports:
//   req_i   : request vector
//   ptr_i   : index with highest priority (must be < NUM_REQ)
//   grant_o : index of the picked requester (0 when none)
//   found_o : at least one request was set
// -----------------------------------------------------------------------------
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [ID_W-1:0]    ptr_i,
   output logic [ID_W-1:0]    grant_o,
   output logic               found_o
);

   localparam int IW = ID_W + 1;
   localparam logic [IW-1:0] NUM_REQ_W = IW'(NUM_REQ);

   // cand_idx[k] is the requester examined at scan offset k from ptr_i.
   logic [IW-1:0]   sum_w    [NUM_REQ];
   logic [ID_W-1:0] cand_idx [NUM_REQ];
   logic [NUM_REQ-1:0] hit_w;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
         assign sum_w[gi]    = {1'b0, ptr_i} + IW'(gi);
         assign cand_idx[gi] = (sum_w[gi] >= NUM_REQ_W) ? ID_W'(sum_w[gi] - NUM_REQ_W)
                                                         : ID_W'(sum_w[gi]);
         assign hit_w[gi]    = req_i[cand_idx[gi]];
      end
   endgenerate

   // Walk offsets from the far end so the smallest hit offset is written last.
   always_comb begin
      grant_o = '0;
      found_o = 1'b0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (hit_w[k]) begin
            grant_o = cand_idx[k];
            found_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/online_div_scheduler.sv
// -----------------------------------------------------------------------------
// online_div_scheduler
// Time-shares one online signed-digit divider between NUM_REQ requesters.
// A round-robin pick grants one requester, the divider is cleared for one
// cycle, the owner's x/d digits are streamed in followed by ONLINE_DELAY zero
// digits, and the divider's q stream is routed back to the owner with the
// first ONLINE_DELAY digits discarded.
// Ports:
//   clk, asyn_reset          : clock, synchronous active-high reset
//   op_req/op_x/op_d/op_vld  : requester side operand stream (per requester)
//   op_rdy                   : operand ready, only ever set for the owner
//   res_q/res_vld/res_rdy    : result digit stream back to the owner
//   div_clr                  : one-cycle divider clear before each operation
//   div_x/div_d/div_in_vld/div_in_rdy : divider operand stream
//   div_q/div_q_vld/div_q_rdy         : divider quotient stream
//   grant_id, busy, done     : owner index, operation active, completion pulse
// -----------------------------------------------------------------------------
module online_div_scheduler
   import online_div_pkg::*;
#(
   parameter int NUM_REQ      = 4,
   parameter int DIGITS       = 64,
   parameter int ONLINE_DELAY = 3,
   parameter int ID_W         = 2
) (
   input  logic                 clk,
   input  logic                 asyn_reset,
   input  logic [NUM_REQ-1:0]   op_req,
   input  logic [2*NUM_REQ-1:0] op_x,
   input  logic [2*NUM_REQ-1:0] op_d,
   input  logic [NUM_REQ-1:0]   op_vld,
   output logic [NUM_REQ-1:0]   op_rdy,
   output logic [1:0]           res_q,
   output logic [NUM_REQ-1:0]   res_vld,
   input  logic [NUM_REQ-1:0]   res_rdy,
   output logic                 div_clr,
   output logic [1:0]           div_x,
   output logic [1:0]           div_d,
   output logic                 div_in_vld,
   input  logic                 div_in_rdy,
   input  logic [1:0]           div_q,
   input  logic                 div_q_vld,
   output logic                 div_q_rdy,
   output logic [ID_W-1:0]      grant_id,
   output logic                 busy,
   output logic [NUM_REQ-1:0]   done
);

   localparam int CW = cnt_width(DIGITS, ONLINE_DELAY);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);
   localparam logic [CW-1:0] CNT_DIG   = CW'(DIGITS);
   localparam logic [CW-1:0] CNT_DELAY = CW'(ONLINE_DELAY);
   localparam logic [CW-1:0] CNT_TOTAL = CW'(DIGITS + ONLINE_DELAY);

   state_e          state_q, state_d;
   logic [ID_W-1:0] grant_q, grant_d;
   logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [CW-1:0]   in_cnt_q, in_cnt_d;
   logic [CW-1:0]   out_cnt_q, out_cnt_d;

   logic [ID_W-1:0]    arb_grant;
   logic               arb_found;
   logic [NUM_REQ-1:0] owner_oh;
   logic [1:0]         sel_x;
   logic [1:0]         sel_d;
   logic               sel_vld;
   logic               sel_res_rdy;
   logic               feed_rdy;
   logic               done_pulse;
   logic               out_win;
   logic               q_drop;
   logic               q_fwd;
   logic               q_acc;

   // --------------------------------------------------------------------------
   // Arbitration
   // --------------------------------------------------------------------------
   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_rr_arbiter (
      .req_i   (op_req),
      .ptr_i   (rr_ptr_q),
      .grant_o (arb_grant),
      .found_o (arb_found)
   );

   // --------------------------------------------------------------------------
   // Owner selection
   // --------------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_owner
         assign owner_oh[gi] = (grant_q == ID_W'(gi));
      end
   endgenerate

   assign sel_x       = op_x[{grant_q, 1'b0} +: 2];
   assign sel_d       = op_d[{grant_q, 1'b0} +: 2];
   assign sel_vld     = op_vld[grant_q];
   assign sel_res_rdy = res_rdy[grant_q];

   // --------------------------------------------------------------------------
   // Output path: open from the cycle after CLEAR until the end of DRAIN.
   // The first ONLINE_DELAY beats are swallowed here; the rest pass straight
   // through to the owner with no added latency, so res_rdy backpressure only
   // throttles the divider output and never the operand feed.
   // --------------------------------------------------------------------------
   assign out_win = (state_q == FEED) || (state_q == PAD) || (state_q == DRAIN);
   assign q_drop  = out_win && (out_cnt_q < CNT_DELAY);
   assign q_fwd   = out_win && (out_cnt_q >= CNT_DELAY) && (out_cnt_q < CNT_TOTAL);

   assign div_q_rdy = q_drop || (q_fwd && sel_res_rdy);
   assign q_acc     = div_q_vld && div_q_rdy;
   assign res_q     = q_fwd ? div_q : SD_ZERO;
   assign res_vld   = owner_oh & {NUM_REQ{q_fwd && div_q_vld}};

   assign op_rdy   = owner_oh & {NUM_REQ{feed_rdy}};
   assign done     = owner_oh & {NUM_REQ{done_pulse}};
   assign grant_id = grant_q;

   // --------------------------------------------------------------------------
   // Next-state and operand-side outputs
   // --------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      rr_ptr_d   = rr_ptr_q;
      in_cnt_d   = in_cnt_q;
      out_cnt_d  = out_cnt_q;
      div_clr    = 1'b0;
      div_x      = SD_ZERO;
      div_d      = SD_ZERO;
      div_in_vld = 1'b0;
      feed_rdy   = 1'b0;
      busy       = 1'b0;
      done_pulse = 1'b0;

      // The output counter runs independently of the input phase and holds
      // at its terminal value.
      if (q_acc && (out_cnt_q != CNT_TOTAL)) begin
         out_cnt_d = out_cnt_q + CNT_ONE;
      end

      case (state_q)
         IDLE: begin
            if (arb_found) begin
               grant_d  = arb_grant;
               rr_ptr_d = (arb_grant == ID_W'(NUM_REQ - 1)) ? '0 : arb_grant + 1'b1;
               state_d  = CLEAR;
            end
         end

         CLEAR: begin
            busy      = 1'b1;
            div_clr   = 1'b1;
            in_cnt_d  = '0;
            out_cnt_d = '0;
            state_d   = FEED;
         end

         FEED: begin
            busy       = 1'b1;
            div_x      = sel_x;
            div_d      = sel_d;
            div_in_vld = sel_vld;
            feed_rdy   = div_in_rdy;
            // Leave on the accepting edge of the last operand digit so no
            // extra owner digit is ever presented to the divider.
            if (sel_vld && div_in_rdy) begin
               in_cnt_d = in_cnt_q + CNT_ONE;
               if (in_cnt_q == CNT_DIG - CNT_ONE) begin
                  state_d = PAD;
               end
            end
         end

         PAD: begin
            busy       = 1'b1;
            div_in_vld = 1'b1;
            if (div_in_rdy) begin
               in_cnt_d = in_cnt_q + CNT_ONE;
               if (in_cnt_q == CNT_TOTAL - CNT_ONE) begin
                  state_d = DRAIN;
               end
            end
         end

         DRAIN: begin
            busy = 1'b1;
            if (out_cnt_q == CNT_TOTAL) begin
               done_pulse = 1'b1;
               in_cnt_d   = '0;
               out_cnt_d  = '0;
               state_d    = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // --------------------------------------------------------------------------
   // State registers
   // --------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (asyn_reset) begin
         state_q   <= IDLE;
         grant_q   <= '0;
         rr_ptr_q  <= '0;
         in_cnt_q  <= '0;
         out_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         rr_ptr_q  <= rr_ptr_d;
         in_cnt_q  <= in_cnt_d;
         out_cnt_q <= out_cnt_d;
      end
   end

endmodule

// File: tb/tb_online_div_scheduler.sv
// -----------------------------------------------------------------------------
// tb_online_div_scheduler
// Directed bench for online_div_scheduler. A divider stub echoes each accepted
// x digit as the matching q digit one cycle later, so the owner must receive
// its own x digits 3..63 followed by three zeros. An operation-level model
// tracks owner, accepted-digit and delivered-digit counts and predicts every
// visible output each cycle.
// -----------------------------------------------------------------------------
module tb_online_div_scheduler;
   import online_div_pkg::*;

   localparam int N   = 4;
   localparam int DIG = 64;
   localparam int OD  = 3;
   localparam int IDW = 2;
   localparam int TOT = DIG + OD;

   logic           clk = 1'b0;
   logic           asyn_reset;
   logic [N-1:0]   op_req, op_vld, op_rdy, res_vld, res_rdy, done;
   logic [2*N-1:0] op_x, op_d;
   logic [1:0]     res_q, div_x, div_d, div_q;
   logic           div_clr, div_in_vld, div_in_rdy, div_q_vld, div_q_rdy, busy;
   logic [IDW-1:0] grant_id;

   always #5 clk = ~clk;

   online_div_scheduler #(
      .NUM_REQ(N), .DIGITS(DIG), .ONLINE_DELAY(OD), .ID_W(IDW)
   ) dut (
      .clk(clk), .asyn_reset(asyn_reset),
      .op_req(op_req), .op_x(op_x), .op_d(op_d), .op_vld(op_vld), .op_rdy(op_rdy),
      .res_q(res_q), .res_vld(res_vld), .res_rdy(res_rdy),
      .div_clr(div_clr), .div_x(div_x), .div_d(div_d),
      .div_in_vld(div_in_vld), .div_in_rdy(div_in_rdy),
      .div_q(div_q), .div_q_vld(div_q_vld), .div_q_rdy(div_q_rdy),
      .grant_id(grant_id), .busy(busy), .done(done)
   );

   int checks = 0;
   int errors = 0;

   // requester data and stimulus knobs
   logic [1:0]   rx [N][DIG];
   logic [1:0]   rd [N][DIG];
   int           rptr [N];
   logic [N-1:0] req_mask = '0;
   bit vld_rand = 0, q_toggle = 0, spurious_q = 0, auto_drop = 1, tog = 0, post_reset = 0;
   int hole_at = -1, hole_left = 0;

   // divider stub
   logic [1:0] sq[$];

   // model
   int m_phase = 0;   // 0 idle, 1 clearing, 2 operation running
   int m_owner = 0, m_rr = 0, m_in = 0, m_out = 0, op_act = 0;
   logic [1:0] exp_res[$];
   int grants[$];
   int done_cnt [N];
   int total_done = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int last_grant();
      return (grants.size() > 0) ? grants[grants.size()-1] : -1;
   endfunction

   // One clock cycle: drive at negedge, check and advance the model 1 ns later.
   task automatic step();
      int own;
      logic [N-1:0] own_mask, exp_done;
      bit in_acc, out_acc, found;
      logic [1:0] xd;
      @(negedge clk);
      op_req = req_mask;
      for (int r = 0; r < N; r++) begin
         if (rptr[r] < DIG) begin
            op_vld[r]      = vld_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            op_x[2*r +: 2] = rx[r][rptr[r]];
            op_d[2*r +: 2] = rd[r][rptr[r]];
         end else begin
            op_vld[r]      = 1'b0;
            op_x[2*r +: 2] = 2'b00;
            op_d[2*r +: 2] = 2'b00;
         end
      end
      div_in_rdy = (hole_left == 0);
      if (hole_left > 0) hole_left--;
      tog = ~tog;
      res_rdy = '1;
      if (q_toggle) res_rdy[1] = tog;
      div_q_vld = (sq.size() > 0) || (spurious_q && m_phase == 0);
      div_q     = (sq.size() > 0) ? sq[0] : 2'b11;
      #1;

      own      = m_owner;
      own_mask = '0;
      exp_done = '0;
      if (m_phase == 2) own_mask[own] = 1'b1;
      if (m_phase == 2 && m_in == TOT && m_out == TOT) exp_done[own] = 1'b1;

      chk("busy", busy, m_phase != 0);
      chk("div_clr", div_clr, m_phase == 1);
      chk("grant_id", grant_id, own);
      chk("done", done, exp_done);
      chk("op_rdy_nonowner", op_rdy & ~own_mask, 0);
      chk("res_vld_nonowner", res_vld & ~own_mask, 0);
      if (post_reset) begin
         chk("reset_div_x", div_x, 0);
         chk("reset_div_d", div_d, 0);
         chk("reset_res_q", res_q, 0);
         post_reset = 0;
      end

      in_acc  = 0;
      out_acc = 0;
      if (m_phase == 2) begin
         if (m_in < DIG) begin
            chk("div_in_vld_feed", div_in_vld, op_vld[own]);
            chk("op_rdy_owner", op_rdy[own], div_in_rdy);
            if (op_vld[own]) begin
               chk("div_x", div_x, rx[own][m_in]);
               chk("div_d", div_d, rd[own][m_in]);
            end
            in_acc = op_vld[own] && div_in_rdy;
         end else if (m_in < TOT) begin
            chk("div_in_vld_pad", div_in_vld, 1);
            chk("pad_digits", {div_x, div_d}, 0);
            in_acc = div_in_rdy;
         end else begin
            chk("div_in_vld_drain", div_in_vld, 0);
         end
         if (m_out < OD) begin
            chk("div_q_rdy_drop", div_q_rdy, 1);
            chk("res_vld_drop", res_vld[own], 0);
            out_acc = div_q_vld;
         end else if (m_out < TOT) begin
            chk("div_q_rdy_fwd", div_q_rdy, res_rdy[own]);
            chk("res_vld_fwd", res_vld[own], div_q_vld);
            if (div_q_vld && exp_res.size() > 0) chk("res_q", res_q, exp_res[0]);
            out_acc = div_q_vld && res_rdy[own];
         end
      end else begin
         chk("div_in_vld_idle", div_in_vld, 0);
         chk("div_q_rdy_idle", div_q_rdy, 0);
         chk("op_rdy_idle", op_rdy, 0);
         chk("res_vld_idle", res_vld, 0);
      end

      // divider stub follows what the DUT actually drove
      if (div_clr) sq.delete();
      if (div_q_vld && div_q_rdy && sq.size() > 0) void'(sq.pop_front());
      if (div_in_vld && div_in_rdy) sq.push_back(div_x);
      if (m_phase == 2 && res_vld[own] && res_rdy[own]) op_act++;

      // model advance
      if (out_acc) begin
         if (m_out >= OD) void'(exp_res.pop_front());
         m_out++;
      end
      if (in_acc) begin
         xd = (m_in < DIG) ? rx[own][m_in] : 2'b00;
         if (m_in >= OD) exp_res.push_back(xd);
         if (m_in < DIG) rptr[own]++;
         m_in++;
         if (m_in == hole_at) hole_left = 5;
      end
      case (m_phase)
         0: if (req_mask != 0) begin
            found = 0;
            for (int k = 0; k < N; k++) begin
               if (!found && req_mask[(m_rr + k) % N]) begin
                  found   = 1;
                  m_owner = (m_rr + k) % N;
               end
            end
            grants.push_back(m_owner);
            m_rr    = (m_owner + 1) % N;
            m_phase = 1;
            $display("[%0t] grant requester %0d", $time, m_owner);
         end
         1: begin
            m_phase = 2;
            m_in    = 0;
            m_out   = 0;
            op_act  = 0;
            exp_res.delete();
         end
         default: if (exp_done != 0) begin
            chk("op_digits_delivered", op_act, DIG);
            done_cnt[own]++;
            total_done++;
            rptr[own] = 0;
            if (auto_drop) req_mask[own] = 1'b0;
            m_phase = 0;
            $display("[%0t] done requester %0d, %0d q digits delivered", $time, own, op_act);
         end
      endcase
   endtask

   task automatic do_reset(input int ncyc);
      @(negedge clk);
      asyn_reset = 1'b1;
      op_vld     = '0;
      div_q_vld  = 1'b0;
      div_in_rdy = 1'b0;
      repeat (ncyc) @(posedge clk);
      #1 asyn_reset = 1'b0;
      m_phase = 0; m_owner = 0; m_rr = 0; m_in = 0; m_out = 0;
      hole_left = 0;
      sq.delete();
      exp_res.delete();
      for (int r = 0; r < N; r++) rptr[r] = 0;
      post_reset = 1;
      $display("[%0t] reset applied for %0d cycle(s)", $time, ncyc);
   endtask

   task automatic run_ops(input int n, input int budget);
      int target;
      int c;
      target = total_done + n;
      c = 0;
      while (total_done < target && c < budget) begin
         step();
         c++;
      end
      chk("ops_completed_in_budget", total_done, target);
   endtask

   initial begin
      int rr_start, c, done_before;
      int rr_exp [5];
      rr_exp = '{0, 1, 2, 3, 0};
      for (int r = 0; r < N; r++) begin
         rptr[r] = 0;
         done_cnt[r] = 0;
         for (int i = 0; i < DIG; i++) begin
            c = $urandom_range(0, 2);
            rx[r][i] = (c == 0) ? SD_ZERO : (c == 1) ? SD_POS : SD_NEG;
            c = $urandom_range(0, 2);
            rd[r][i] = (c == 0) ? SD_ZERO : (c == 1) ? SD_POS : SD_NEG;
         end
      end
      rx[2][10] = 2'b11;  // illegal code must pass through untouched
      asyn_reset = 1'b1; op_req = '0; op_vld = '0; op_x = '0; op_d = '0;
      res_rdy = '0; div_in_rdy = 1'b0; div_q = 2'b00; div_q_vld = 1'b0;

      // reset state
      do_reset(2);
      repeat (3) step();
      chk("lit_reset_busy", busy, 0);
      chk("lit_reset_grant_id", grant_id, 0);

      // single operation on requester 2
      req_mask = 4'b0100;
      run_ops(1, 400);
      chk("lit_single_grant", last_grant(), 2);
      chk("lit_single_grant_id", grant_id, 2);
      chk("lit_single_done_cnt", done_cnt[2], 1);
      repeat (2) step();
      chk("lit_single_busy_after", busy, 0);

      // round robin with all requests held
      do_reset(1);
      auto_drop = 0;
      req_mask  = 4'b1111;
      rr_start  = grants.size();
      run_ops(5, 2000);
      req_mask  = '0;
      auto_drop = 1;
      for (int i = 0; i < 5; i++) begin
         if (rr_start + i < grants.size()) chk("lit_rr_order", grants[rr_start + i], rr_exp[i]);
         else chk("lit_rr_order_missing", grants.size(), rr_start + 5);
      end
      chk("lit_rr_grant_id", grant_id, 0);

      // output backpressure on requester 1
      q_toggle = 1;
      req_mask = 4'b0010;
      run_ops(1, 600);
      q_toggle = 0;
      chk("lit_bp_grant", last_grant(), 1);
      chk("lit_bp_done_cnt", done_cnt[1], 2);

      // input stalls on requester 3
      vld_rand = 1;
      hole_at  = 20;
      req_mask = 4'b1000;
      run_ops(1, 1200);
      vld_rand = 0;
      hole_at  = -1;
      chk("lit_stall_done_cnt", done_cnt[3], 2);

      // reset in the middle of an operation on requester 2
      req_mask = 4'b0100;
      c = 0;
      while (!(m_phase == 2 && m_in == 30) && c < 200) begin
         step();
         c++;
      end
      chk("reach_in_cnt_30", m_in, 30);
      done_before = done_cnt[2];
      do_reset(1);
      req_mask = '0;
      step();
      chk("lit_midreset_done", done, 0);
      chk("lit_midreset_busy", busy, 0);
      req_mask = 4'b1001;
      run_ops(1, 400);
      req_mask = '0;
      chk("lit_after_reset_grant", last_grant(), 0);
      chk("lit_midreset_no_done2", done_cnt[2], done_before);

      // owner drops its request; spurious divider output while idle
      spurious_q = 1;
      req_mask   = 4'b0010;
      c = 0;
      while (m_phase == 0 && c < 10) begin
         step();
         c++;
      end
      req_mask = '0;
      run_ops(1, 400);
      repeat (4) step();
      spurious_q = 0;
      chk("lit_drop_done_cnt", done_cnt[1], 3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

endmodule
